// File: rtl/mdu_pkg.sv
// Shared constants for the EX-stage multiply/divide sequencer: funct3 op codes,
// M-extension decode constants and the sequencer state encoding.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [6:0] OPC_M_EXT    = 7'b0110011;
  localparam logic [6:0] FUNCT7_M_EXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // rs1 is taken as signed by MULH, MULHSU, DIV and REM; MUL only needs the low
  // half, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on a
// {hi, lo} accumulator of width 2*XLEN.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          ge;

  always_comb begin
    mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Partial remainder shifted left with the next dividend bit pulled in.
    trial   = acc_i[2*XLEN-1:XLEN-1];
    diff    = trial - {1'b0, operand_i};
    ge      = (trial >= {1'b0, operand_i});
    if (is_div_i) begin
      if (ge) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else    acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer beside the EX stage.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU/REM/REMU retire at once with 0.
module ex_mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_lat_q, wreg_lat_d;
  logic              done_q, done_d;
  logic              wreg_o_q, wreg_o_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              stall;
  logic              sa, sb;
  logic              is_div;
  logic [2*XLEN-1:0] acc_nxt;

  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  // Final sign correction and half/quotient/remainder selection.
  function automatic logic [XLEN-1:0] fix_result(input logic [2:0]        op,
                                                 input logic [2*XLEN-1:0] acc,
                                                 input logic              neg_a,
                                                 input logic              neg_b,
                                                 input logic              div0);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    prod = (neg_a ^ neg_b) ? ('0 - acc) : acc;
    quot = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    if (op[2]) begin
      // Divide by zero leaves the all-ones quotient untouched; remainder keeps dividend sign.
      if (!op[1]) return ((neg_a ^ neg_b) && !div0) ? ('0 - quot) : quot;
      else        return neg_a ? ('0 - rem) : rem;
    end
`else
    if (div0 && quot == '0 && rem == '0) return '0;
`endif
    if (op == OP_MUL) return prod[XLEN-1:0];
    return prod[2*XLEN-1:XLEN];
  endfunction

`ifdef MDU_DIV_EN
  assign is_div = op_q[2];
`else
  assign is_div = 1'b0;
`endif

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div),
    .acc_o     (acc_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    wd_d       = wd_q;
    wreg_lat_d = wreg_lat_q;
    done_d     = 1'b0;
    wreg_o_d   = 1'b0;
    wdata_d    = wdata_q;
    stall      = 1'b0;
    sa         = op_signed_a(op_i) & reg1_i[XLEN-1];
    sb         = op_signed_b(op_i) & reg2_i[XLEN-1];
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          stall      = 1'b1;
          op_d       = op_i;
          wd_d       = wd_i;
          wreg_lat_d = wreg_i;
          neg_a_d    = sa;
          neg_b_d    = sb;
          opnd_d     = abs_if(reg2_i, sb);
          acc_d      = {{XLEN{1'b0}}, abs_if(reg1_i, sa)};
          cnt_d      = '0;
`ifndef MDU_DIV_EN
          if (op_i[2]) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            wreg_o_d = wreg_i;
            wdata_d  = '0;
          end else begin
            state_d  = ST_BUSY;
          end
`else
          state_d = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        stall = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          wdata_d  = fix_result(op_q, acc_q, neg_a_q, neg_b_q, opnd_q == '0);
          state_d  = ST_DONE;
          done_d   = 1'b1;
          wreg_o_d = wreg_lat_q;
        end
      end
      ST_DONE: begin
        // A flush or a new valid here is deliberately ignored; the op retires now.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      wd_q       <= '0;
      wreg_lat_q <= 1'b0;
      done_q     <= 1'b0;
      wreg_o_q   <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      wd_q       <= wd_d;
      wreg_lat_q <= wreg_lat_d;
      done_q     <= done_d;
      wreg_o_q   <= wreg_o_d;
      wdata_q    <= wdata_d;
    end
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
  end

  assign stall_o = stall;
  assign done_o  = done_q;
  assign wd_o    = wd_q;
  assign wreg_o  = wreg_o_q;
  assign wdata_o = wdata_q;

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Self-checking bench for ex_mdu_seq: directed vector table, flush/reset sequences
// and randomized ops against a plain-arithmetic RV32M reference model.
module tb_ex_mdu_seq;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;

  int total = 0;
  int bad   = 0;

  ex_mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .op_i    (op_i),
    .reg1_i  (reg1_i),
    .reg2_i  (reg2_i),
    .wd_i    (wd_i),
    .wreg_i  (wreg_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .wd_o    (wd_o),
    .wreg_o  (wreg_o),
    .wdata_o (wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural RV32M results from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
`ifndef MDU_DIV_EN
    if (op >= 3'd4) return 32'd0;
`endif
    case (op)
      3'd0: begin r = ua * ub; return r[31:0]; end
      3'd1: begin sp = sa * sb; r = sp; return r[63:32]; end
      3'd2: begin sp = sa * longint'(ub); r = sp; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; r = sp; return r[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        r = ua / ub; return r[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; r = sp; return r[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        r = ua % ub; return r[31:0];
      end
    endcase
  endfunction

  // Cycles from the accept cycle to the done_o cycle.
  function automatic int ref_latency(input logic [2:0] op);
`ifndef MDU_DIV_EN
    if (op >= 3'd4) return 1;
`endif
    return 34;
  endfunction

  // Entered just after a negedge with the sequencer idle; leaves it idle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic [4:0] wd, input logic wreg,
                       input logic poke_done, input string tag);
    int   lat;
    int   stall_hi;
    logic early;
    lat      = ref_latency(op);
    stall_hi = 0;
    early    = 1'b0;
    valid_i  = 1'b1;
    op_i     = op;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wreg;
    #1;
    chk({tag, " stall_accept"}, 32'(stall_o), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
      op_i    = 3'($urandom);
      reg1_i  = $urandom;
      reg2_i  = $urandom;
      wd_i    = 5'($urandom);
      wreg_i  = 1'($urandom);
      if (k == lat && poke_done) begin
        valid_i = 1'b1;
        op_i    = 3'd0;
      end
      #1;
      if (k < lat) begin
        stall_hi += int'(stall_o);
        if (done_o) early = 1'b1;
      end
    end
    chk({tag, " stall_cycles"}, 32'(stall_hi), 32'(lat - 1));
    chk({tag, " early_done"}, 32'(early), 32'd0);
    chk({tag, " done"}, 32'(done_o), 32'd1);
    chk({tag, " wdata"}, wdata_o, exp);
    chk({tag, " wd"}, 32'(wd_o), 32'(wd));
    chk({tag, " wreg"}, 32'(wreg_o), 32'(wreg));
    chk({tag, " stall_done"}, 32'(stall_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    chk({tag, " done_drop"}, 32'(done_o), 32'd0);
    chk({tag, " wreg_drop"}, 32'(wreg_o), 32'd0);
    chk({tag, " wdata_hold"}, wdata_o, exp);
    chk({tag, " idle_stall"}, 32'(stall_o), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] held;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'd42};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[4]  = '{3'd0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE};
    vecs[5]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[8]  = '{3'd5, 32'd100,        32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'd100,        32'd0,          32'd100};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[12] = '{3'd4, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF};
    vecs[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
    vecs[14] = '{3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[16] = '{3'd5, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[17] = '{3'd4, 32'd9,          32'd3,          32'd3};
`ifndef MDU_DIV_EN
    for (int i = 0; i < 18; i++) if (vecs[i].op[2]) vecs[i].exp = 32'd0;
`endif

    rst = 1'b1; valid_i = 1'b0; op_i = '0; reg1_i = '0; reg2_i = '0;
    wd_i = '0; wreg_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset wreg", 32'(wreg_o), 32'd0);
    chk("reset wd", 32'(wd_o), 32'd0);
    chk("reset wdata", wdata_o, 32'd0);

    for (int i = 0; i < 18; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 5'(i + 1), 1'(i != 3),
            1'(i == 2 || i == 9), $sformatf("vec%0d", i));

    // Flush in the middle of an iteration, then an immediate back-to-back MUL.
    held = wdata_o;
    valid_i = 1'b1; op_i = 3'd0; reg1_i = 32'd3; reg2_i = 32'd5; wd_i = 5'd9; wreg_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush stall", 32'(stall_o), 32'd0);
    chk("flush done", 32'(done_o), 32'd0);
    chk("flush wdata", wdata_o, held);
    do_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, 5'd11, 1'b1, 1'b0, "after_flush");

    // Reset in the middle of an iteration.
    valid_i = 1'b1; op_i = 3'd3; reg1_i = 32'hDEAD_BEEF; reg2_i = 32'h1234_5678;
    wd_i = 5'd17; wreg_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst stall", 32'(stall_o), 32'd0);
    chk("midrst done", 32'(done_o), 32'd0);
    chk("midrst wreg", 32'(wreg_o), 32'd0);
    chk("midrst wd", 32'(wd_o), 32'd0);
    chk("midrst wdata", wdata_o, 32'd0);
    do_op(3'd0, 32'd7, 32'd6, 32'd42, 5'd5, 1'b1, 1'b0, "after_rst");

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      do_op(rop, ra, rb, ref_result(rop, ra, rb), 5'($urandom), 1'($urandom),
            1'(n % 9 == 0), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
